// File: rtl/eth_vlg_link_ctl.sv
// Link bring-up controller for eth_vlg: sequences DHCP attempts with watchdog, backoff,
// static fallback and lease renewal, and gates ARP/TCP on address validity.
module eth_vlg_link_ctl #(
  parameter int STARTUP_TICKS   = 125,
  parameter int DHCP_WAIT_TICKS = 1250000,
  parameter int DHCP_RETRIES    = 3,
  parameter int BACKOFF_TICKS   = 125000,
  parameter int LEASE_TICKS     = 0,
  parameter int FALLBACK_ENABLE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_preferredIpv4,
  input  logic        i_renew,
  output logic        o_dhcpStart,
  input  logic        i_dhcpSuccess,
  input  logic        i_dhcpFail,
  input  logic [31:0] i_assignedIpv4,
  output logic [31:0] o_ipv4Addr,
  output logic        o_ready,
  output logic        o_error,
  output logic        o_arpRst,
  input  logic        i_tcpConnectIn,
  input  logic        i_tcpListenIn,
  output logic        o_tcpConnect,
  output logic        o_tcpListen,
  output logic [2:0]  o_tries,
  output logic [2:0]  o_state
);

  localparam int STARTUP_N = (STARTUP_TICKS < 1) ? 1 : STARTUP_TICKS;
  localparam int WAIT_N    = (DHCP_WAIT_TICKS < 1) ? 1 : DHCP_WAIT_TICKS;
  localparam int BACKOFF_N = (BACKOFF_TICKS < 1) ? 1 : BACKOFF_TICKS;
  // tries saturates at 7, so a larger retry budget is clamped to keep exhaustion reachable
  localparam int RETRY_N   = (DHCP_RETRIES < 1) ? 1 : ((DHCP_RETRIES > 7) ? 7 : DHCP_RETRIES);
  localparam int TICK_MAX0 = (STARTUP_N > WAIT_N) ? STARTUP_N : WAIT_N;
  localparam int TICK_MAX  = (TICK_MAX0 > BACKOFF_N) ? TICK_MAX0 : BACKOFF_N;
  localparam int TICK_W    = $clog2(TICK_MAX) + 1;
  localparam int LEASE_W   = $clog2(LEASE_TICKS) + 1;
  localparam int LEASE_END = (LEASE_TICKS > 0) ? LEASE_TICKS - 1 : 0;

  localparam logic [TICK_W-1:0]  STARTUP_LAST = TICK_W'(STARTUP_N - 1);
  localparam logic [TICK_W-1:0]  WAIT_LAST    = TICK_W'(WAIT_N - 1);
  localparam logic [TICK_W-1:0]  BACKOFF_LAST = TICK_W'(BACKOFF_N - 1);
  localparam logic [LEASE_W-1:0] LEASE_LAST   = LEASE_W'(LEASE_END);

  typedef enum logic [2:0] {
    ST_STARTUP  = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_BACKOFF  = 3'd3,
    ST_BOUND    = 3'd4,
    ST_FALLBACK = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  state_t              r_state;
  logic [TICK_W-1:0]   r_tick;
  logic [LEASE_W-1:0]  r_leaseCnt;
  logic                r_bound;

  logic w_retryLeft;
  logic w_waitExpired;
  logic w_leaseDue;

  assign w_retryLeft   = (o_tries < 3'(RETRY_N));
  assign w_waitExpired = (r_tick == WAIT_LAST);
  assign w_leaseDue    = (LEASE_TICKS != 0) && (r_leaseCnt == LEASE_LAST);
  assign o_state       = r_state;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_STARTUP;
      r_tick       <= '0;
      r_leaseCnt   <= '0;
      r_bound      <= 1'b0;
      o_dhcpStart  <= 1'b0;
      o_ipv4Addr   <= '0;
      o_ready      <= 1'b0;
      o_error      <= 1'b0;
      o_arpRst     <= 1'b1;
      o_tcpConnect <= 1'b0;
      o_tcpListen  <= 1'b0;
      o_tries      <= '0;
    end else begin
      o_dhcpStart  <= 1'b0;
      o_arpRst     <= ~o_ready;
      o_tcpConnect <= i_tcpConnectIn & o_ready;
      o_tcpListen  <= i_tcpListenIn & o_ready;

      case (r_state)
        ST_STARTUP: begin
          if (r_tick == STARTUP_LAST) begin
            r_tick  <= '0;
            r_state <= ST_START;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        ST_START: begin
          o_dhcpStart <= 1'b1;
          if (o_tries != 3'd7) o_tries <= o_tries + 1'b1;
          r_tick  <= '0;
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          r_tick <= r_tick + 1'b1;
          if (i_dhcpSuccess) begin
            r_tick     <= '0;
            o_ipv4Addr <= i_assignedIpv4;
            o_ready    <= 1'b1;
            r_bound    <= 1'b1;
            o_tries    <= '0;
            r_leaseCnt <= '0;
            r_state    <= ST_BOUND;
          end else if (i_dhcpFail || w_waitExpired) begin
            r_tick <= '0;
            if (w_retryLeft) begin
              r_state <= ST_BACKOFF;
            end else begin
              // A failed renewal keeps serving the previously bound address
              o_error <= 1'b1;
              if (r_bound) begin
                r_state <= ST_BOUND;
              end else if (FALLBACK_ENABLE != 0) begin
                o_ipv4Addr <= i_preferredIpv4;
                o_ready    <= 1'b1;
                r_state    <= ST_FALLBACK;
              end else begin
                o_ipv4Addr <= '0;
                o_ready    <= 1'b0;
                r_state    <= ST_ERROR;
              end
            end
          end
        end

        ST_BACKOFF: begin
          if (r_tick == BACKOFF_LAST) begin
            r_tick  <= '0;
            r_state <= ST_START;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        ST_BOUND: begin
          o_ready <= 1'b1;
          if (i_renew || w_leaseDue) begin
            r_leaseCnt <= '0;
            o_tries    <= '0;
            r_state    <= ST_START;
          end else if (LEASE_TICKS != 0) begin
            r_leaseCnt <= r_leaseCnt + 1'b1;
          end
        end

        ST_FALLBACK: begin
          if (i_renew) begin
            o_tries <= '0;
            o_ready <= 1'b0;
            r_state <= ST_START;
          end else begin
            o_ipv4Addr <= i_preferredIpv4;
            o_ready    <= 1'b1;
          end
        end

        ST_ERROR: begin
          o_ready    <= 1'b0;
          o_ipv4Addr <= '0;
          if (i_renew) begin
            o_tries <= '0;
            r_state <= ST_START;
          end
        end

        default: r_state <= ST_STARTUP;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_vlg_link_ctl.sv
// Scoreboard bench for eth_vlg_link_ctl: instance A has fallback and no lease,
// instance B has no fallback and a 50-cycle lease; only one is out of reset at a time.
module tb_eth_vlg_link_ctl;

  typedef struct {
    int          dut;
    bit          isStart;
    int          cycle;
    logic [2:0]  tries;
    logic        rdy;
    logic        err;
    logic [31:0] ip;
  } evt_t;

  logic        clk;
  logic        rstN      [2];
  logic [31:0] prefIp    [2];
  logic        renewV    [2];
  logic        succV     [2];
  logic        failV     [2];
  logic [31:0] assignedV [2];
  logic        tcIn      [2];
  logic        tlIn      [2];
  logic        startV    [2];
  logic [31:0] ipV       [2];
  logic        rdyV      [2];
  logic        errV      [2];
  logic        arpV      [2];
  logic        tcpCV     [2];
  logic        tcpLV     [2];
  logic [2:0]  triesV    [2];
  logic [2:0]  stateV    [2];

  logic [33:0] prevStat [2];
  evt_t        expQ [$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          monOn = 0;

  eth_vlg_link_ctl #(
    .STARTUP_TICKS(4), .DHCP_WAIT_TICKS(100), .DHCP_RETRIES(3),
    .BACKOFF_TICKS(10), .LEASE_TICKS(0), .FALLBACK_ENABLE(1)
  ) dutA (
    .i_clk(clk), .i_rst_n(rstN[0]), .i_preferredIpv4(prefIp[0]), .i_renew(renewV[0]),
    .o_dhcpStart(startV[0]), .i_dhcpSuccess(succV[0]), .i_dhcpFail(failV[0]),
    .i_assignedIpv4(assignedV[0]), .o_ipv4Addr(ipV[0]), .o_ready(rdyV[0]), .o_error(errV[0]),
    .o_arpRst(arpV[0]), .i_tcpConnectIn(tcIn[0]), .i_tcpListenIn(tlIn[0]),
    .o_tcpConnect(tcpCV[0]), .o_tcpListen(tcpLV[0]), .o_tries(triesV[0]), .o_state(stateV[0])
  );

  eth_vlg_link_ctl #(
    .STARTUP_TICKS(4), .DHCP_WAIT_TICKS(100), .DHCP_RETRIES(3),
    .BACKOFF_TICKS(10), .LEASE_TICKS(50), .FALLBACK_ENABLE(0)
  ) dutB (
    .i_clk(clk), .i_rst_n(rstN[1]), .i_preferredIpv4(prefIp[1]), .i_renew(renewV[1]),
    .o_dhcpStart(startV[1]), .i_dhcpSuccess(succV[1]), .i_dhcpFail(failV[1]),
    .i_assignedIpv4(assignedV[1]), .o_ipv4Addr(ipV[1]), .o_ready(rdyV[1]), .o_error(errV[1]),
    .o_arpRst(arpV[1]), .i_tcpConnectIn(tcIn[1]), .i_tcpListenIn(tlIn[1]),
    .o_tcpConnect(tcpCV[1]), .o_tcpListen(tcpLV[1]), .o_tries(triesV[1]), .o_state(stateV[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void expectStart(int d, int c, int t);
    evt_t e;
    e.dut = d; e.isStart = 1'b1; e.cycle = c; e.tries = 3'(t);
    e.rdy = 1'b0; e.err = 1'b0; e.ip = '0;
    expQ.push_back(e);
  endfunction

  function automatic void expectStatus(int d, int c, logic r, logic er, logic [31:0] ip);
    evt_t e;
    e.dut = d; e.isStart = 1'b0; e.cycle = c; e.tries = '0;
    e.rdy = r; e.err = er; e.ip = ip;
    expQ.push_back(e);
  endfunction

  task automatic handleEvent(int d, bit isStart);
    evt_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpectedEvent at cycle %0d: dut %0d start=%0b, expected no event", cyc, d, isStart);
    end else begin
      e = expQ.pop_front();
      checkOutput("evtDut", 32'(d), 32'(e.dut));
      checkOutput("evtKind", {31'b0, isStart}, {31'b0, e.isStart});
      checkOutput("evtCycle", 32'(cyc), 32'(e.cycle));
      if (isStart) begin
        checkOutput("startTries", {29'b0, triesV[d]}, {29'b0, e.tries});
      end else begin
        checkOutput("statusReady", {31'b0, rdyV[d]}, {31'b0, e.rdy});
        checkOutput("statusError", {31'b0, errV[d]}, {31'b0, e.err});
        checkOutput("statusIp", ipV[d], e.ip);
      end
    end
  endtask

  // Monitor: every start pulse and every change of {ready,error,ipv4} must match the queue head
  always @(negedge clk) begin
    if (monOn) begin
      for (int i = 0; i < 2; i++) begin
        if (startV[i] === 1'b1) handleEvent(i, 1'b1);
        if ({rdyV[i], errV[i], ipV[i]} !== prevStat[i]) begin
          handleEvent(i, 1'b0);
          prevStat[i] = {rdyV[i], errV[i], ipV[i]};
        end
      end
    end
  end

  task automatic waitUntil(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Holds the given inputs so they are sampled on posedge number edgeC
  task automatic applyStimulus(int d, int edgeC, logic s, logic f, logic rn, logic [31:0] ip);
    waitUntil(edgeC - 1);
    succV[d] = s; failV[d] = f; renewV[d] = rn; assignedV[d] = ip;
    waitUntil(edgeC);
    succV[d] = 1'b0; failV[d] = 1'b0; renewV[d] = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int r, p, x, q, lp;
    for (int i = 0; i < 2; i++) begin
      rstN[i] = 1'b0; renewV[i] = 1'b0; succV[i] = 1'b0; failV[i] = 1'b0;
      assignedV[i] = '0; tcIn[i] = 1'b0; tlIn[i] = 1'b0; prevStat[i] = '0;
    end
    prefIp[0] = 32'hC0A800D1;
    prefIp[1] = 32'h0A0A0A0A;

    waitUntil(3);
    checkOutput("rstState", {29'b0, stateV[0]}, 32'd0);
    checkOutput("rstArp", {31'b0, arpV[0]}, 32'd1);
    checkOutput("rstReady", {31'b0, rdyV[0]}, 32'd0);
    checkOutput("rstStart", {31'b0, startV[0]}, 32'd0);
    checkOutput("rstTries", {29'b0, triesV[0]}, 32'd0);
    checkOutput("rstIp", ipV[0], 32'd0);
    checkOutput("rstTcp", {30'b0, tcpCV[0], tcpLV[0]}, 32'd0);
    monOn = 1'b1;

    // Nominal bring-up: success on 5th WAIT cycle
    waitUntil(5);
    r = cyc; p = r + 5;
    expectStart(0, p, 1);
    expectStatus(0, p + 5, 1'b1, 1'b0, 32'hC0A8002A);
    rstN[0] = 1'b1;
    applyStimulus(0, p + 5, 1'b1, 1'b0, 1'b0, 32'hC0A8002A);
    checkOutput("nomTries", {29'b0, triesV[0]}, 32'd0);
    checkOutput("nomArpBefore", {31'b0, arpV[0]}, 32'd1);
    checkOutput("nomState", {29'b0, stateV[0]}, 32'd4);
    tcIn[0] = 1'b1;
    waitUntil(p + 6);
    checkOutput("nomArpAfter", {31'b0, arpV[0]}, 32'd0);
    checkOutput("nomTcpConnect", {31'b0, tcpCV[0]}, 32'd1);
    checkOutput("nomTcpListen", {31'b0, tcpLV[0]}, 32'd0);

    // Reset while bound, then reset in the middle of WAIT
    waitUntil(p + 10);
    x = cyc;
    expectStatus(0, x + 1, 1'b0, 1'b0, 32'h0);
    rstN[0] = 1'b0;
    waitUntil(x + 1);
    checkOutput("rstBoundTcp", {31'b0, tcpCV[0]}, 32'd0);
    checkOutput("rstBoundArp", {31'b0, arpV[0]}, 32'd1);
    tcIn[0] = 1'b0;
    waitUntil(x + 2);
    r = cyc; p = r + 5;
    expectStart(0, p, 1);
    rstN[0] = 1'b1;
    waitUntil(p + 20);
    x = cyc;
    rstN[0] = 1'b0;
    waitUntil(x + 1);
    checkOutput("midWaitState", {29'b0, stateV[0]}, 32'd0);
    checkOutput("midWaitTries", {29'b0, triesV[0]}, 32'd0);
    checkOutput("midWaitStart", {31'b0, startV[0]}, 32'd0);
    waitUntil(x + 3);

    // Retry: fail attempt 1, success ignored in BACKOFF, success+fail together on attempt 2
    r = cyc; p = r + 5;
    expectStart(0, p, 1);
    expectStart(0, p + 14, 2);
    expectStatus(0, p + 16, 1'b1, 1'b0, 32'h0A000007);
    rstN[0] = 1'b1;
    applyStimulus(0, p + 3, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(0, p + 6, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    checkOutput("backoffState", {29'b0, stateV[0]}, 32'd3);
    checkOutput("backoffReady", {31'b0, rdyV[0]}, 32'd0);
    applyStimulus(0, p + 16, 1'b1, 1'b1, 1'b0, 32'h0A000007);
    waitUntil(p + 17);
    checkOutput("retryState", {29'b0, stateV[0]}, 32'd4);
    checkOutput("retryError", {31'b0, errV[0]}, 32'd0);
    checkOutput("retryTries", {29'b0, triesV[0]}, 32'd0);

    // Watchdog exhaustion into FALLBACK, then renew from FALLBACK
    waitUntil(p + 20);
    x = cyc;
    expectStatus(0, x + 1, 1'b0, 1'b0, 32'h0);
    rstN[0] = 1'b0;
    waitUntil(x + 2);
    r = cyc; p = r + 5;
    expectStart(0, p, 1);
    expectStart(0, p + 111, 2);
    expectStart(0, p + 222, 3);
    expectStatus(0, p + 322, 1'b1, 1'b1, 32'hC0A800D1);
    rstN[0] = 1'b1;
    waitUntil(p + 99);
    checkOutput("wdogLastWait", {29'b0, stateV[0]}, 32'd2);
    waitUntil(p + 100);
    checkOutput("wdogExpired", {29'b0, stateV[0]}, 32'd3);
    waitUntil(p + 323);
    checkOutput("fallbackState", {29'b0, stateV[0]}, 32'd5);
    checkOutput("fallbackTries", {29'b0, triesV[0]}, 32'd3);
    expectStatus(0, p + 330, 1'b0, 1'b1, 32'hC0A800D1);
    expectStart(0, p + 331, 1);
    applyStimulus(0, p + 330, 1'b0, 1'b0, 1'b1, 32'h0);
    waitUntil(p + 340);
    x = cyc;
    expectStatus(0, x + 1, 1'b0, 1'b0, 32'h0);
    rstN[0] = 1'b0;
    waitUntil(x + 3);

    // Instance B: all attempts fail with no fallback -> ERROR, TCP stays gated
    failV[1] = 1'b1; tcIn[1] = 1'b1; tlIn[1] = 1'b1;
    r = cyc; p = r + 5;
    expectStart(1, p, 1);
    expectStart(1, p + 12, 2);
    expectStart(1, p + 24, 3);
    expectStatus(1, p + 25, 1'b0, 1'b1, 32'h0);
    rstN[1] = 1'b1;
    waitUntil(p + 26);
    checkOutput("errState", {29'b0, stateV[1]}, 32'd6);
    checkOutput("errReady", {31'b0, rdyV[1]}, 32'd0);
    checkOutput("errIp", ipV[1], 32'd0);
    checkOutput("errTries", {29'b0, triesV[1]}, 32'd3);
    checkOutput("errTcpListen", {31'b0, tcpLV[1]}, 32'd0);
    waitUntil(p + 30);
    checkOutput("errTcpConnect", {31'b0, tcpCV[1]}, 32'd0);
    failV[1] = 1'b0;

    // Renew out of ERROR, bind, then lease-driven renewal that fails
    q = p + 32;
    expectStart(1, q + 1, 1);
    expectStatus(1, q + 3, 1'b1, 1'b1, 32'hC0A80164);
    applyStimulus(1, q, 1'b0, 1'b0, 1'b1, 32'h0);
    applyStimulus(1, q + 3, 1'b1, 1'b0, 1'b0, 32'hC0A80164);
    waitUntil(q + 4);
    checkOutput("boundTcpConnect", {31'b0, tcpCV[1]}, 32'd1);
    checkOutput("boundTcpListen", {31'b0, tcpLV[1]}, 32'd1);
    checkOutput("boundArp", {31'b0, arpV[1]}, 32'd0);
    lp = q + 54;
    expectStart(1, lp, 1);
    expectStart(1, lp + 12, 2);
    expectStart(1, lp + 24, 3);
    waitUntil(q + 40);
    failV[1] = 1'b1;
    waitUntil(lp + 5);
    checkOutput("renewReadyHeld", {31'b0, rdyV[1]}, 32'd1);
    checkOutput("renewIpHeld", ipV[1], 32'hC0A80164);
    waitUntil(lp + 26);
    failV[1] = 1'b0;
    checkOutput("renewFailState", {29'b0, stateV[1]}, 32'd4);
    checkOutput("renewFailReady", {31'b0, rdyV[1]}, 32'd1);
    checkOutput("renewFailIp", ipV[1], 32'hC0A80164);
    checkOutput("renewFailError", {31'b0, errV[1]}, 32'd1);

    // Manual renew that succeeds replaces the address
    expectStart(1, lp + 31, 1);
    expectStatus(1, lp + 33, 1'b1, 1'b1, 32'hC0A80165);
    applyStimulus(1, lp + 30, 1'b0, 1'b0, 1'b1, 32'h0);
    applyStimulus(1, lp + 33, 1'b1, 1'b0, 1'b0, 32'hC0A80165);
    waitUntil(lp + 36);
    checkOutput("renewOkState", {29'b0, stateV[1]}, 32'd4);

    waitUntil(cyc + 5);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_vlg_link_ctl.md
Name: eth_vlg_link_ctl

Overview:
Bring-up and address-lifecycle controller for the eth_vlg core.
- Sequences the DHCP engine: start pulse, per-attempt watchdog, retry backoff, fallback to a static address, periodic lease renewal.
- Drives the device IPv4 address, the core ready/error status, ARP reset, and TCP connect/listen gating.
- Sits between the user status/control pins and dhcp_ctl/arp/tcp_ctl inside the top level, replacing ad-hoc gating logic there.

Parameters:
STARTUP_TICKS, 125, cycles to wait after reset release before the first DHCP attempt (minimum 1)
DHCP_WAIT_TICKS, 1250000, watchdog per attempt; expiry counts as a failed attempt
DHCP_RETRIES, 3, attempts per acquisition cycle; 0 is treated as 1
BACKOFF_TICKS, 125000, idle cycles between a failed attempt and the next start pulse
LEASE_TICKS, 0, cycles spent in BOUND before automatic renewal; 0 disables renewal
FALLBACK_ENABLE, 1, 1: use preferred_ipv4 after retries are exhausted; 0: enter ERROR

Ports:
clk  in  1  core clock, 125 MHz
rst_n  in  1  synchronous reset, active low
preferred_ipv4  in  32  static/fallback address
renew  in  1  single-cycle request for immediate re-acquisition
dhcp_start  out  1  single-cycle start pulse to the DHCP engine
dhcp_success  in  1  DHCP engine success (level or pulse)
dhcp_fail  in  1  DHCP engine failure (level or pulse)
assigned_ipv4  in  32  DHCP-assigned address, valid with dhcp_success
ipv4_addr  out  32  device IPv4 address
ready  out  1  address valid; traffic enabled
error  out  1  sticky: retries exhausted at least once
arp_rst  out  1  ARP table reset (equals !ready, registered)
tcp_connect_in  in  1  user connect request
tcp_listen_in  in  1  user listen request
tcp_connect  out  1  gated connect to tcp_ctl
tcp_listen  out  1  gated listen to tcp_ctl
tries  out  3  attempts made in the current acquisition cycle
state  out  3  FSM encoding, for debug

Behaviour:
- Reset (rst_n=0 at posedge): FSM=STARTUP; counters=0; ipv4_addr=0; dhcp_start=0; ready=0; error=0; tries=0; arp_rst=1; tcp_connect=tcp_listen=0; internal bound flag=0.
- Reset asserted in any state aborts the operation in progress. No dhcp_start is issued during reset or on the cycle reset deasserts.
- All outputs are registered.
  - tcp_connect = tcp_connect_in & ready, 1-cycle latency; same rule for tcp_listen.
  - arp_rst = !ready, 1-cycle latency after ready.
- STARTUP: count STARTUP_TICKS cycles, then go to START.
- START: dhcp_start=1 for exactly one cycle; tries increments (saturates at 7); clear the watchdog; go to WAIT.
- WAIT: the watchdog counts up. Checks in priority order:
  - dhcp_success: ipv4_addr<=assigned_ipv4; ready<=1; bound<=1; tries<=0; lease counter<=0; go to BOUND. Success wins over a simultaneous dhcp_fail or watchdog expiry.
  - dhcp_fail, or watchdog reaches DHCP_WAIT_TICKS-1: if tries<max(DHCP_RETRIES,1), go to BACKOFF. Otherwise the cycle is exhausted: error<=1 and
    - bound=1: go to BOUND, keeping the old ipv4_addr;
    - else FALLBACK_ENABLE=1: go to FALLBACK;
    - else go to ERROR.
- BACKOFF: count BACKOFF_TICKS cycles, then go to START. Success or fail inputs arriving here are ignored.
- BOUND: ready=1.
  - The lease counter increments each cycle.
  - renew=1, or (LEASE_TICKS!=0 and counter==LEASE_TICKS-1): tries<=0; go to START.
  - ready and ipv4_addr are held through renewal, so TCP sessions are not disturbed.
  - A renewal success replaces ipv4_addr in the cycle it is latched.
- FALLBACK: ipv4_addr<=preferred_ipv4; ready<=1; stay. renew: tries<=0; ready<=0; go to START.
- ERROR: ready=0; ipv4_addr=0; stay. renew: tries<=0; go to START.
- renew is ignored in STARTUP, START, WAIT and BACKOFF.
- error clears only on reset.
- Counters are sized with $clog2 of their parameter plus 1 and must never wrap. Counter comparisons use equality against parameter-1.

Test Plan:
Use STARTUP=4, WAIT=100, BACKOFF=10, RETRIES=3, LEASE=0 unless stated.
- Nominal bring-up: release rst_n; success with assigned_ipv4=192.168.0.42 on the 5th cycle of WAIT -> dhcp_start pulses once at cycle 5 after reset release; ready=1 and ipv4_addr=C0A8002A one cycle after success; arp_rst falls one cycle later; tries=0.
- Retry then success: fail on attempt 1; success on attempt 2 -> two dhcp_start pulses separated by ≥10 idle BACKOFF cycles; ready=1; error=0.
- Watchdog exhaustion with fallback: no response -> exactly 3 start pulses, each WAIT 100 cycles; then error=1, ready=1, ipv4_addr=preferred_ipv4 (192.168.0.209).
- FALLBACK_ENABLE=0 with fail on all 3 attempts -> ERROR state; ready=0; ipv4_addr=0; tcp_connect stays 0 while tcp_connect_in=1. A renew pulse -> a new start pulse with tries=1.
- Renewal with LEASE=50, renewal attempts all fail -> ready stays 1 throughout, old ipv4_addr retained, error=1. A subsequent successful renew replaces ipv4_addr.
- Simultaneous success and fail in WAIT -> BOUND. Reset asserted mid-WAIT -> all outputs return to reset values on the next edge, and no spurious start pulse appears.
